// File: rtl/uart_wb_bridge_pkg.sv
// Shared constants and types for the UART-to-Wishbone command bridge.
package uart_wb_bridge_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_ERR  = 8'h45;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_DATA     = 3'd2,
    ST_REQ      = 3'd3,
    ST_WAIT_ACK = 3'd4,
    ST_RESP     = 3'd5
  } state_e;

endpackage

// File: rtl/rsp_serializer.sv
// Response shifter: holds either a full read word or one status byte and
// streams it out MSB first over a valid/ready byte interface.
module rsp_serializer #(
  parameter int unsigned DATA_BYTES = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_load_word,
  input  logic                    i_load_byte,
  input  logic [DATA_BYTES*8-1:0] i_word,
  input  logic [7:0]              i_byte,
  output logic [7:0]              o_tx_data,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic                    o_last_c
);

  localparam int unsigned W     = DATA_BYTES * 8;
  localparam int unsigned CNT_W = $clog2(DATA_BYTES + 1);

  logic [W-1:0]     sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;

  // cnt_q counts bytes still waiting behind the one currently presented
  always_comb begin
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (i_load_word) begin
      data_d  = i_word[W-1 -: 8];
      sh_d    = {i_word[W-9:0], 8'h00};
      cnt_d   = CNT_W'(DATA_BYTES - 1);
      valid_d = 1'b1;
    end else if (i_load_byte) begin
      data_d  = i_byte;
      sh_d    = '0;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (valid_q && i_tx_ready) begin
      if (cnt_q == '0) begin
        valid_d = 1'b0;
        data_d  = 8'h00;
      end else begin
        data_d = sh_q[W-1 -: 8];
        sh_d   = {sh_q[W-9:0], 8'h00};
        cnt_d  = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sh_q    <= '0;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign o_tx_data  = data_q;
  assign o_tx_valid = valid_q;
  assign o_last_c   = (cnt_q == '0);

endmodule

// File: rtl/uart_wb_bridge.sv
// Byte-stream command bridge: parses 'W'/'R' frames from the UART and issues
// one pipelined Wishbone request per frame, returning the result as bytes.
module uart_wb_bridge
  import uart_wb_bridge_pkg::*;
#(
  parameter int unsigned WB_ADDR_BITS   = 24,
  parameter int unsigned WB_DATA_BITS   = 128,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [7:0]                i_rx_data,
  input  logic                      i_rx_valid,
  output logic                      o_rx_ready,
  output logic [7:0]                o_tx_data,
  output logic                      o_tx_valid,
  input  logic                      i_tx_ready,
  output logic                      o_wb_cyc,
  output logic                      o_wb_stb,
  output logic                      o_wb_we,
  output logic [WB_ADDR_BITS-1:0]   o_wb_addr,
  output logic [WB_DATA_BITS-1:0]   o_wb_data,
  output logic [WB_DATA_BITS/8-1:0] o_wb_sel,
  input  logic                      i_wb_stall,
  input  logic                      i_wb_ack,
  input  logic [WB_DATA_BITS-1:0]   i_wb_data,
  input  logic                      i_calib_done,
  output logic                      o_busy
);

  localparam int unsigned ADDR_BYTES = (WB_ADDR_BITS + 7) / 8;
  localparam int unsigned DATA_BYTES = WB_DATA_BITS / 8;
  localparam int unsigned MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int unsigned BCNT_W     = $clog2(MAX_BYTES + 1);
  localparam int unsigned TO_W       = $clog2(TIMEOUT_CYCLES + 1);

  state_e                  state_q, state_d;
  logic [BCNT_W-1:0]       bcnt_q, bcnt_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
  logic [WB_ADDR_BITS-1:0] addr_q, addr_d;
  logic [WB_DATA_BITS-1:0] wdata_q, wdata_d;
  logic                    is_write_q, is_write_d;
  logic                    rx_ready_q, rx_ready_d;
  logic                    cyc_q, cyc_d;
  logic                    stb_q, stb_d;
  logic                    we_q, we_d;
  logic                    busy_q, busy_d;

  logic                    rx_fire;
  logic                    tx_fire;
  logic                    tx_last_c;
  logic                    load_word_c;
  logic                    load_byte_c;
  logic [7:0]              rsp_byte_c;

  assign rx_fire = i_rx_valid && rx_ready_q;
  assign tx_fire = o_tx_valid && i_tx_ready;

  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    to_cnt_d    = to_cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    is_write_d  = is_write_q;
    load_word_c = 1'b0;
    load_byte_c = 1'b0;
    rsp_byte_c  = RSP_OK;

    case (state_q)
      ST_IDLE: begin
        if (rx_fire && (i_rx_data == OP_WRITE || i_rx_data == OP_READ)) begin
          is_write_d = (i_rx_data == OP_WRITE);
          if (i_calib_done) begin
            state_d  = ST_ADDR;
            bcnt_d   = '0;
            to_cnt_d = '0;
          end else begin
            load_byte_c = 1'b1;
            rsp_byte_c  = RSP_ERR;
            state_d     = ST_RESP;
          end
        end
      end
      ST_ADDR: begin
        if (rx_fire) begin
          addr_d   = WB_ADDR_BITS'({addr_q, i_rx_data});
          to_cnt_d = '0;
          if (bcnt_q == BCNT_W'(ADDR_BYTES - 1)) begin
            bcnt_d  = '0;
            state_d = is_write_q ? ST_DATA : ST_REQ;
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d  = ST_IDLE;
          to_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_DATA: begin
        if (rx_fire) begin
          wdata_d  = WB_DATA_BITS'({wdata_q, i_rx_data});
          to_cnt_d = '0;
          if (bcnt_q == BCNT_W'(DATA_BYTES - 1)) begin
            bcnt_d  = '0;
            state_d = ST_REQ;
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d  = ST_IDLE;
          to_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_REQ: begin
        if (!i_wb_stall) state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (i_wb_ack) begin
          state_d = ST_RESP;
          if (is_write_q) load_byte_c = 1'b1;
          else            load_word_c = 1'b1;
        end
      end
      ST_RESP: begin
        if (tx_fire && tx_last_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered images of the state being entered
    rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_ADDR) || (state_d == ST_DATA);
    stb_d      = (state_d == ST_REQ);
    cyc_d      = (state_d == ST_REQ) || (state_d == ST_WAIT_ACK);
    we_d       = cyc_d && is_write_d;
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      bcnt_q     <= '0;
      to_cnt_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      rx_ready_q <= 1'b0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      to_cnt_q   <= to_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      rx_ready_q <= rx_ready_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
    end
  end

  rsp_serializer #(
    .DATA_BYTES (DATA_BYTES)
  ) u_rsp (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load_word (load_word_c),
    .i_load_byte (load_byte_c),
    .i_word      (i_wb_data),
    .i_byte      (rsp_byte_c),
    .o_tx_data   (o_tx_data),
    .o_tx_valid  (o_tx_valid),
    .i_tx_ready  (i_tx_ready),
    .o_last_c    (tx_last_c)
  );

  assign o_rx_ready = rx_ready_q;
  assign o_wb_cyc   = cyc_q;
  assign o_wb_stb   = stb_q;
  assign o_wb_we    = we_q;
  assign o_wb_addr  = addr_q;
  assign o_wb_data  = wdata_q;
  assign o_wb_sel   = '1;
  assign o_busy     = busy_q;

endmodule

// File: doc/uart_wb_bridge.md
# uart_wb_bridge

Byte-stream command bridge between the board UART (AXI-Stream byte interface, RX and TX) and the Wishbone user port of the DDR3 controller. It parses framed read/write commands carrying a full address and a full controller-width data word. It issues exactly one pipelined Wishbone request per command and streams the result back as bytes. It replaces ad-hoc single-character test logic in board top levels.

## Interface
- WB_ADDR_BITS, 24, width of o_wb_addr; ADDR_BYTES = ceil(WB_ADDR_BITS/8)
- WB_DATA_BITS, 128, width of Wishbone data (8 × LANES × 8); DATA_BYTES = WB_DATA_BITS/8
- TIMEOUT_CYCLES, 1_000_000, maximum idle clocks between bytes of one frame
- i_clk  in  1  controller clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  received byte valid
- o_rx_ready  out  1  bridge accepts byte
- o_tx_data  out  8  byte to transmit
- o_tx_valid  out  1  tx byte valid
- i_tx_ready  in  1  UART accepts tx byte
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone request
- o_wb_addr  out  WB_ADDR_BITS  burst address
- o_wb_data  out  WB_DATA_BITS  write data
- o_wb_sel  out  DATA_BYTES  byte enables, always all ones
- i_wb_stall, i_wb_ack  in  1 each  Wishbone response
- i_wb_data  in  WB_DATA_BITS  read data
- i_calib_done  in  1  controller calibration complete
- o_busy  out  1  high in every state except IDLE

## Operation
- Frame: opcode, then ADDR_BYTES address bytes MSB first, then (write only) DATA_BYTES data bytes MSB first. Opcodes: 'W' 0x57, 'R' 0x52.
- Byte transfer on both streams = valid && ready, same cycle.
- States: IDLE, ADDR, DATA, REQ, WAIT_ACK, RESP.
- IDLE: opcode W/R with i_calib_done=1 -> ADDR, byte counter cleared. Opcode W/R with i_calib_done=0 -> RESP with single byte 'E' 0x45. Any other byte is consumed and dropped.
- ADDR: shift in bytes. After the last one, go to DATA (write) or REQ (read).
- DATA: shift in bytes. After the last one -> REQ.
- REQ: cyc=stb=1, we per opcode. Stb held with stable addr/data until a cycle with i_wb_stall=0, then -> WAIT_ACK with stb=0, cyc=1.
- WAIT_ACK: on i_wb_ack, cyc=0. Read: latch i_wb_data into response register, -> RESP with DATA_BYTES bytes MSB first. Write: -> RESP with single byte 'K' 0x4B.
- RESP: o_tx_valid=1. Advance to the next byte on each tx handshake. After the last handshake -> IDLE.
- o_rx_ready=1 only in IDLE, ADDR, DATA. Bytes arriving in other states are back-pressured, not lost.
- Timeout: in ADDR/DATA, a counter reloads on every accepted byte. When it reaches TIMEOUT_CYCLES with no byte -> IDLE, frame discarded, no response. No timeout in REQ/WAIT_ACK/RESP.
- An ack seen outside WAIT_ACK is ignored.

## Timing
- Reset values: o_rx_ready=0 during the reset cycle, then 1 (IDLE). o_tx_valid=0, o_tx_data=0, o_wb_cyc=o_wb_stb=o_wb_we=0, o_wb_addr=0, o_wb_data=0, o_wb_sel=all ones, o_busy=0. State=IDLE, counters zero.
- All outputs registered. Stb rises the cycle after the last frame byte is accepted.
- With stall=0, stb is high for exactly 1 cycle.
- o_tx_valid rises the cycle after the ack is sampled. o_tx_data is stable while valid && !ready.
- Reset mid-operation: next cycle is IDLE with all outputs at reset values. An outstanding Wishbone transaction is abandoned by dropping cyc.
- Byte counter width is clog2(max(ADDR_BYTES, DATA_BYTES)+1). Address bytes beyond WB_ADDR_BITS are truncated, keeping the LSBs.

## Structure
- Package uart_wb_bridge_pkg: opcode constants (OP_WRITE, OP_READ, RSP_OK, RSP_ERR) and the state enum.
- One sub-module, rsp_serializer: a DATA_BYTES-wide load/shift register with a byte count and a valid/ready output. It is loaded with either the read word or a single status byte.

## Test plan
- Write then read: send 'W', 00 00 10, 16 bytes 00..0F -> one stb with we=1, addr=0x000010, data=0x000102…0F, sel=0xFFFF; tx 'K'. Then 'R' 00 00 10 -> tx 00..0F in order.
- Stall: hold i_wb_stall=1 for 5 cycles during REQ -> stb stays high 6 cycles with addr/data unchanged; exactly one request issued.
- Calibration gating: i_calib_done=0, send 'R' -> tx single 0x45, no cyc. Following address bytes are treated as opcodes and dropped.
- Timeout: TIMEOUT_CYCLES=100, send 'W' 00, then silence for 100 cycles -> return to IDLE, no Wishbone activity. Then a full 'R' frame -> normal read.
- TX backpressure: i_tx_ready low for 20 cycles during a read response -> data held, no byte lost or duplicated; o_rx_ready=0 throughout.
- Reset after stb asserted with stall=1 -> next cycle cyc=stb=0, IDLE, o_busy=0.
